// File: rtl/dtw_ref_pkg.sv
// Shared types and helpers for the multi-port DTW reference store:
// controller state encoding, op-mode constants and packed-bus slice offsets.
package dtw_ref_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REF_LOAD = 2'd1,
    DTW_READ = 2'd2
  } state_e;

  localparam logic MODE_DTW_READ = 1'b0;
  localparam logic MODE_LOAD_REF = 1'b1;

  function automatic int slice_off(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/dtw_ref_bank.sv
// One reference bank: single write port, single read port with a registered
// (1-cycle) read. Contents are never reset.
module dtw_ref_bank
  import dtw_ref_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int PTR_WIDTH  = 20
) (
  input  logic                  clk_in,
  input  logic                  we_in,
  input  logic [PTR_WIDTH-1:0]  waddr_in,
  input  logic [DATA_WIDTH-1:0] wdata_in,
  input  logic                  re_in,
  input  logic [PTR_WIDTH-1:0]  raddr_in,
  output logic [DATA_WIDTH-1:0] rdata_out
);

  logic [DATA_WIDTH-1:0] mem_q [2**PTR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_in) begin
    if (we_in) mem_q[waddr_in] <= wdata_in;
    if (re_in) rdata_q <= mem_q[raddr_in];
  end

  assign rdata_out = rdata_q;

endmodule

// File: rtl/dtw_ref_mem_multi.sv
// Multi-port DTW reference store: loads a reference from the source FIFO into
// one bank per read port. Define DTW_REF_DBG_EN to expose debug ports.
module dtw_ref_mem_multi
  import dtw_ref_pkg::*;
#(
  parameter int DATA_WIDTH       = 16,
  parameter int ADDR_WIDTH       = 32,
  parameter int REFMEM_PTR_WIDTH = 20,
  parameter int NUM_READ_PORTS   = 4,
  parameter int REF_INIT         = 0
) (
  input  logic                                   clk_in,
  input  logic                                   rst_in,
  input  logic                                   rs_in,
  input  logic                                   op_mode_in,
  input  logic [ADDR_WIDTH-1:0]                  ref_len_in,
  output logic                                   busy_out,
  output logic                                   ref_load_done_out,
  output logic                                   len_err_out,
  output logic [ADDR_WIDTH-1:0]                  ref_count_out,
  output logic                                   src_fifo_clear_out,
  output logic                                   src_fifo_rden_out,
  input  logic                                   src_fifo_empty_in,
  input  logic [DATA_WIDTH-1:0]                  src_fifo_data_in,
  input  logic [NUM_READ_PORTS-1:0]              rd_en_in,
  input  logic [NUM_READ_PORTS*REFMEM_PTR_WIDTH-1:0] rd_addr_in,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0]   rd_data_out,
`ifdef DTW_REF_DBG_EN
  output logic [1:0]                             dbg_state,
  output logic [ADDR_WIDTH-1:0]                  dbg_addr_ref,
  output logic                                   dbg_wren_ref,
`endif
  output logic [NUM_READ_PORTS-1:0]              rd_valid_out
);

  localparam int PW = REFMEM_PTR_WIDTH;
  localparam longint unsigned DEPTH = 64'd1 << PW;

  if (NUM_READ_PORTS < 1 || NUM_READ_PORTS > 16 || REF_INIT < 0 || REF_INIT > 1) begin : g_bad_param
    $error("dtw_ref_mem_multi: unsupported NUM_READ_PORTS or REF_INIT");
  end

  state_e state_q, state_d;
  logic [PW:0] len_q, len_d, count_q, count_d, issued_q, issued_d, issued_next;
  logic rden_q, rden_d, wr_q, wr_d, done_q, done_d;
  logic len_err_q, len_err_d, clear_q, clear_d;
  logic [NUM_READ_PORTS-1:0] rd_valid_q, rd_valid_d, in_range_q, in_range_d;
  logic accepted, len_too_big;
  logic [DATA_WIDTH-1:0] bank_rdata [NUM_READ_PORTS];

  assign accepted    = rden_q && !src_fifo_empty_in;
  assign issued_next = issued_q + {{PW{1'b0}}, accepted};
  assign len_too_big = 64'(ref_len_in) > DEPTH;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    count_d   = count_q;
    issued_d  = issued_next;
    rden_d    = 1'b0;
    wr_d      = accepted;
    done_d    = done_q;
    len_err_d = len_err_q;
    clear_d   = 1'b0;
    if (wr_q && count_q < len_q) count_d = count_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (rs_in && op_mode_in == MODE_LOAD_REF) begin
          if (len_too_big) begin
            len_err_d = 1'b1;
          end else begin
            len_d     = ref_len_in[PW:0];
            count_d   = '0;
            issued_d  = '0;
            done_d    = 1'b0;
            len_err_d = 1'b0;
            state_d   = REF_LOAD;
          end
        end else if (rs_in && done_q) begin
          state_d = DTW_READ;
        end
      end
      REF_LOAD: begin
        if (count_q == len_q) begin
          done_d  = 1'b1;
          state_d = (op_mode_in == MODE_DTW_READ) ? DTW_READ : IDLE;
        end else if (!rs_in) begin
          // A read accepted this cycle still owes a write; leave once it lands.
          if (!accepted) begin
            state_d = IDLE;
            clear_d = 1'b1;
          end
        end else begin
          rden_d = (issued_next < len_q) && !src_fifo_empty_in;
        end
      end
      DTW_READ: begin
        if (!rs_in || op_mode_in == MODE_LOAD_REF) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_valid_d = '0;
    in_range_d = '0;
    for (int p = 0; p < NUM_READ_PORTS; p++) begin
      rd_valid_d[p] = (state_q == DTW_READ) && rd_en_in[p];
      in_range_d[p] = {1'b0, rd_addr_in[slice_off(p, PW) +: PW]} < len_q;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      len_q      <= '0;
      count_q    <= '0;
      issued_q   <= '0;
      rden_q     <= 1'b0;
      wr_q       <= 1'b0;
      done_q     <= 1'b0;
      len_err_q  <= 1'b0;
      clear_q    <= 1'b1;
      rd_valid_q <= '0;
      in_range_q <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      count_q    <= count_d;
      issued_q   <= issued_d;
      rden_q     <= rden_d;
      wr_q       <= wr_d;
      done_q     <= done_d;
      len_err_q  <= len_err_d;
      clear_q    <= clear_d;
      rd_valid_q <= rd_valid_d;
      in_range_q <= in_range_d;
    end
  end

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_bank
    dtw_ref_bank #(
      .DATA_WIDTH(DATA_WIDTH),
      .PTR_WIDTH (PW)
    ) u_bank (
      .clk_in   (clk_in),
      .we_in    (wr_q),
      .waddr_in (count_q[PW-1:0]),
      .wdata_in (src_fifo_data_in),
      .re_in    (rd_valid_d[p]),
      .raddr_in (rd_addr_in[slice_off(p, PW) +: PW]),
      .rdata_out(bank_rdata[p])
    );
    // Out-of-range addresses and idle ports read as zero.
    assign rd_data_out[slice_off(p, DATA_WIDTH) +: DATA_WIDTH] =
      (rd_valid_q[p] && in_range_q[p]) ? bank_rdata[p] : '0;
  end

  assign busy_out           = (state_q != IDLE);
  assign ref_load_done_out  = done_q;
  assign len_err_out        = len_err_q;
  assign ref_count_out      = ADDR_WIDTH'(count_q);
  assign src_fifo_clear_out = clear_q;
  assign src_fifo_rden_out  = rden_q;
  assign rd_valid_out       = rd_valid_q;

`ifdef DTW_REF_DBG_EN
  assign dbg_state    = state_q;
  assign dbg_addr_ref = ADDR_WIDTH'(count_q[PW-1:0]);
  assign dbg_wren_ref = wr_q;
`endif

endmodule

// File: tb/tb_dtw_ref_mem_multi.sv
// Self-checking bench for dtw_ref_mem_multi: FIFO model, reference-contents
// model and a read scoreboard of expected per-cycle port results.
module tb_dtw_ref_mem_multi;

  localparam int DW = 16;
  localparam int AW = 32;
  localparam int PW = 4;
  localparam int NP = 4;
  localparam int DEPTH = 1 << PW;

  typedef struct packed {
    logic [NP-1:0]    valid;
    logic [NP*DW-1:0] data;
  } rd_exp_t;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic rs_in = 1'b0;
  logic op_mode_in = 1'b0;
  logic [AW-1:0] ref_len_in = '0;
  logic busy_out, ref_load_done_out, len_err_out;
  logic [AW-1:0] ref_count_out;
  logic src_fifo_clear_out, src_fifo_rden_out, src_fifo_empty_in;
  logic [DW-1:0] src_fifo_data_in = '0;
  logic [NP-1:0] rd_en_in = '0;
  logic [NP*PW-1:0] rd_addr_in = '0;
  logic [NP*DW-1:0] rd_data_out;
  logic [NP-1:0] rd_valid_out;
`ifdef DTW_REF_DBG_EN
  logic [1:0] dbg_state;
  logic [AW-1:0] dbg_addr_ref;
  logic dbg_wren_ref;
`endif

  rd_exp_t sb_q[$];
  logic [DW-1:0] model_mem [DEPTH];
  int model_len = 0;
  logic [DW-1:0] fifo_mem [64];
  int fifo_wr = 0;
  int fifo_rd = 0;
  int fifo_reads = 0;
  int checks = 0;
  int errors = 0;

  dtw_ref_mem_multi #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REFMEM_PTR_WIDTH(PW),
    .NUM_READ_PORTS(NP), .REF_INIT(0)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rs_in(rs_in), .op_mode_in(op_mode_in),
    .ref_len_in(ref_len_in), .busy_out(busy_out),
    .ref_load_done_out(ref_load_done_out), .len_err_out(len_err_out),
    .ref_count_out(ref_count_out), .src_fifo_clear_out(src_fifo_clear_out),
    .src_fifo_rden_out(src_fifo_rden_out), .src_fifo_empty_in(src_fifo_empty_in),
    .src_fifo_data_in(src_fifo_data_in), .rd_en_in(rd_en_in),
    .rd_addr_in(rd_addr_in), .rd_data_out(rd_data_out),
`ifdef DTW_REF_DBG_EN
    .dbg_state(dbg_state), .dbg_addr_ref(dbg_addr_ref), .dbg_wren_ref(dbg_wren_ref),
`endif
    .rd_valid_out(rd_valid_out)
  );

  always #5 clk_in = ~clk_in;

  // Source FIFO model: data appears the cycle after a read of a non-empty FIFO.
  assign src_fifo_empty_in = (fifo_rd == fifo_wr);
  always @(posedge clk_in) begin
    if (src_fifo_clear_out) begin
      fifo_rd <= fifo_wr;
    end else if (src_fifo_rden_out && !src_fifo_empty_in) begin
      src_fifo_data_in <= fifo_mem[fifo_rd % 64];
      fifo_rd <= fifo_rd + 1;
      fifo_reads <= fifo_reads + 1;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic push_fifo(input logic [DW-1:0] d);
    fifo_mem[fifo_wr % 64] = d;
    fifo_wr = fifo_wr + 1;
  endtask

  task automatic go_idle();
    rs_in = 1'b0;
    op_mode_in = 1'b0;
    rd_en_in = '0;
    tick();
  endtask

  task automatic start_load(input int len);
    rs_in = 1'b1;
    op_mode_in = 1'b1;
    ref_len_in = AW'(len);
    tick();
    op_mode_in = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (ref_load_done_out === 1'b1) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic wait_count(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (ref_count_out === AW'(target)) ok = 1'b1;
      else tick();
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input int a);
    return (a < model_len) ? model_mem[a] : '0;
  endfunction

  task automatic drive_reads(input logic [NP-1:0] en, input logic [NP*PW-1:0] addrs,
                             input bit active);
    rd_exp_t e;
    e = '0;
    rd_en_in = en;
    rd_addr_in = addrs;
    for (int p = 0; p < NP; p++) begin
      e.valid[p] = en[p] && active;
      e.data[p*DW +: DW] = e.valid[p] ? exp_rd(int'(addrs[p*PW +: PW])) : '0;
    end
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    tick(3);
    checks++; if (busy_out !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b want 0", busy_out); end
    checks++; if (ref_load_done_out !== 1'b0) begin errors++; $display("[TB] FAIL rst_done: got %b want 0", ref_load_done_out); end
    checks++; if (len_err_out !== 1'b0) begin errors++; $display("[TB] FAIL rst_len_err: got %b want 0", len_err_out); end
    checks++; if (ref_count_out !== '0) begin errors++; $display("[TB] FAIL rst_count: got %0d want 0", ref_count_out); end
    checks++; if (src_fifo_clear_out !== 1'b1) begin errors++; $display("[TB] FAIL rst_clear: got %b want 1", src_fifo_clear_out); end
    checks++; if (src_fifo_rden_out !== 1'b0) begin errors++; $display("[TB] FAIL rst_rden: got %b want 0", src_fifo_rden_out); end
    checks++; if ({rd_valid_out, rd_data_out} !== '0) begin errors++; $display("[TB] FAIL rst_rd: got valid=%h data=%h want 0", rd_valid_out, rd_data_out); end
    rst_in = 1'b0;
    tick();
    checks++; if (src_fifo_clear_out !== 1'b0) begin errors++; $display("[TB] FAIL clear_release: got %b want 0", src_fifo_clear_out); end
  endtask

  task automatic test_load_read();
    bit ok;
    rd_exp_t e;
    int r0;
    r0 = fifo_reads;
    for (int i = 0; i < 8; i++) begin
      push_fifo(DW'(16'h10 + i));
      model_mem[i] = DW'(16'h10 + i);
    end
    model_len = 8;
    start_load(8);
    wait_done(60, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL load1_done: got timeout want done"); end
    checks++; if (busy_out !== 1'b1) begin errors++; $display("[TB] FAIL load1_busy: got %b want 1", busy_out); end
    checks++; if (ref_count_out !== AW'(8)) begin errors++; $display("[TB] FAIL load1_count: got %0d want 8", ref_count_out); end
    checks++; if (fifo_reads - r0 != 8) begin errors++; $display("[TB] FAIL load1_reads: got %0d want 8", fifo_reads - r0); end
    drive_reads(4'b0100, {4'd0, 4'd5, 4'd0, 4'd0}, 1'b1);
    tick();
    e = sb_q.pop_front();
    checks++; if ({rd_valid_out, rd_data_out} !== {e.valid, e.data}) begin errors++; $display("[TB] FAIL load1_read: got valid=%h data=%h want valid=%h data=%h", rd_valid_out, rd_data_out, e.valid, e.data); end
    rd_en_in = '0;
    tick();
    checks++; if (rd_valid_out !== '0) begin errors++; $display("[TB] FAIL load1_valid_drop: got %b want 0", rd_valid_out); end
  endtask

  task automatic test_fifo_stall();
    bit ok;
    rd_exp_t e;
    int r0;
    go_idle();
    r0 = fifo_reads;
    for (int i = 0; i < 4; i++) push_fifo(DW'(16'h10 + i));
    start_load(8);
    wait_count(4, 40, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL stall_reach4: got timeout want count 4"); end
    tick(3);
    checks++; if (ref_count_out !== AW'(4)) begin errors++; $display("[TB] FAIL stall_count: got %0d want 4", ref_count_out); end
    checks++; if (src_fifo_rden_out !== 1'b0) begin errors++; $display("[TB] FAIL stall_rden: got %b want 0", src_fifo_rden_out); end
    checks++; if (ref_load_done_out !== 1'b0) begin errors++; $display("[TB] FAIL stall_done: got %b want 0", ref_load_done_out); end
    for (int i = 4; i < 8; i++) push_fifo(DW'(16'h10 + i));
    wait_done(60, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL stall_done_wait: got timeout want done"); end
    checks++; if (ref_count_out !== AW'(8) || fifo_reads - r0 != 8) begin errors++; $display("[TB] FAIL stall_final: got count=%0d reads=%0d want 8/8", ref_count_out, fifo_reads - r0); end
    drive_reads(4'hF, {4'd3, 4'd2, 4'd1, 4'd0}, 1'b1);
    tick();
    e = sb_q.pop_front();
    checks++; if ({rd_valid_out, rd_data_out} !== {e.valid, e.data}) begin errors++; $display("[TB] FAIL stall_read_lo: got valid=%h data=%h want valid=%h data=%h", rd_valid_out, rd_data_out, e.valid, e.data); end
    drive_reads(4'hF, {4'd7, 4'd6, 4'd5, 4'd4}, 1'b1);
    tick();
    e = sb_q.pop_front();
    checks++; if ({rd_valid_out, rd_data_out} !== {e.valid, e.data}) begin errors++; $display("[TB] FAIL stall_read_hi: got valid=%h data=%h want valid=%h data=%h", rd_valid_out, rd_data_out, e.valid, e.data); end
    rd_en_in = '0;
  endtask

  task automatic test_len_err();
    bit ok;
    rd_exp_t e;
    int r0;
    go_idle();
    for (int i = 0; i < 4; i++) push_fifo(DW'(16'h40 + i));
    r0 = fifo_reads;
    rs_in = 1'b1;
    op_mode_in = 1'b1;
    ref_len_in = AW'(DEPTH + 1);
    tick();
    checks++; if (len_err_out !== 1'b1) begin errors++; $display("[TB] FAIL len_err_set: got %b want 1", len_err_out); end
    checks++; if (busy_out !== 1'b0) begin errors++; $display("[TB] FAIL len_err_busy: got %b want 0", busy_out); end
    tick(2);
    checks++; if (len_err_out !== 1'b1 || fifo_reads != r0) begin errors++; $display("[TB] FAIL len_err_hold: got err=%b reads=%0d want 1/0", len_err_out, fifo_reads - r0); end
    start_load(4);
    checks++; if (len_err_out !== 1'b0) begin errors++; $display("[TB] FAIL len_err_clear: got %b want 0", len_err_out); end
    for (int i = 0; i < 4; i++) model_mem[i] = DW'(16'h40 + i);
    model_len = 4;
    wait_done(40, ok);
    checks++; if (!ok || ref_count_out !== AW'(4)) begin errors++; $display("[TB] FAIL len4_done: got done=%b count=%0d want 1/4", ok, ref_count_out); end
    drive_reads(4'b0011, {4'd0, 4'd0, 4'd4, 4'd3}, 1'b1);
    tick();
    e = sb_q.pop_front();
    checks++; if ({rd_valid_out, rd_data_out} !== {e.valid, e.data}) begin errors++; $display("[TB] FAIL len4_edge_read: got valid=%h data=%h want valid=%h data=%h", rd_valid_out, rd_data_out, e.valid, e.data); end
    rd_en_in = '0;
  endtask

  task automatic test_abort_reload();
    bit ok;
    rd_exp_t e;
    go_idle();
    for (int i = 0; i < 3; i++) begin
      push_fifo(DW'(16'h50 + i));
      model_mem[i] = DW'(16'h50 + i);
    end
    start_load(8);
    wait_count(3, 40, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL abort_reach3: got timeout want count 3"); end
    rs_in = 1'b0;
    tick();
    checks++; if (busy_out !== 1'b0 || ref_load_done_out !== 1'b0) begin errors++; $display("[TB] FAIL abort_idle: got busy=%b done=%b want 0/0", busy_out, ref_load_done_out); end
    checks++; if (src_fifo_clear_out !== 1'b1) begin errors++; $display("[TB] FAIL abort_clear: got %b want 1", src_fifo_clear_out); end
    checks++; if (ref_count_out !== AW'(3)) begin errors++; $display("[TB] FAIL abort_count: got %0d want 3", ref_count_out); end
    tick();
    checks++; if (src_fifo_clear_out !== 1'b0) begin errors++; $display("[TB] FAIL abort_clear_pulse: got %b want 0", src_fifo_clear_out); end
    push_fifo(16'h0060);
    push_fifo(16'h0061);
    model_mem[0] = 16'h0060;
    model_mem[1] = 16'h0061;
    model_len = 2;
    start_load(2);
    wait_done(40, ok);
    checks++; if (!ok || ref_count_out !== AW'(2)) begin errors++; $display("[TB] FAIL reload_done: got done=%b count=%0d want 1/2", ok, ref_count_out); end
    drive_reads(4'b0111, {4'd0, 4'd2, 4'd1, 4'd0}, 1'b1);
    tick();
    e = sb_q.pop_front();
    checks++; if ({rd_valid_out, rd_data_out} !== {e.valid, e.data}) begin errors++; $display("[TB] FAIL reload_read: got valid=%h data=%h want valid=%h data=%h", rd_valid_out, rd_data_out, e.valid, e.data); end
    rd_en_in = '0;
  endtask

  task automatic test_multi_port();
    bit ok;
    rd_exp_t e;
    go_idle();
    for (int i = 0; i < 8; i++) begin
      push_fifo(DW'(16'h10 + i));
      model_mem[i] = DW'(16'h10 + i);
    end
    model_len = 8;
    start_load(8);
    wait_done(60, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL multi_done: got timeout want done"); end
    drive_reads(4'hF, {4'd9, 4'd3, 4'd7, 4'd0}, 1'b1);
    tick();
    e = sb_q.pop_front();
    checks++; if ({rd_valid_out, rd_data_out} !== {e.valid, e.data}) begin errors++; $display("[TB] FAIL multi_read: got valid=%h data=%h want valid=%h data=%h", rd_valid_out, rd_data_out, e.valid, e.data); end
    go_idle();
    drive_reads(4'hF, {4'd1, 4'd2, 4'd3, 4'd4}, 1'b0);
    tick();
    e = sb_q.pop_front();
    checks++; if ({rd_valid_out, rd_data_out} !== {e.valid, e.data}) begin errors++; $display("[TB] FAIL idle_read_ignored: got valid=%h data=%h want valid=%h data=%h", rd_valid_out, rd_data_out, e.valid, e.data); end
    rd_en_in = '0;
  endtask

  task automatic test_zero_len();
    int r0;
    go_idle();
    push_fifo(16'h0099);
    r0 = fifo_reads;
    start_load(0);
    tick();
    checks++; if (ref_load_done_out !== 1'b1 || busy_out !== 1'b1) begin errors++; $display("[TB] FAIL zero_len_done: got done=%b busy=%b want 1/1", ref_load_done_out, busy_out); end
    checks++; if (fifo_reads != r0 || ref_count_out !== '0) begin errors++; $display("[TB] FAIL zero_len_reads: got reads=%0d count=%0d want 0/0", fifo_reads - r0, ref_count_out); end
  endtask

  task automatic test_reset_midload();
    bit ok;
    go_idle();
    for (int i = 0; i < 8; i++) push_fifo(DW'(16'h70 + i));
    start_load(8);
    wait_count(2, 40, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL midrst_reach2: got timeout want count 2"); end
    rst_in = 1'b1;
    drive_reads(4'hF, {4'd0, 4'd0, 4'd0, 4'd0}, 1'b0);
    tick();
    void'(sb_q.pop_front());
    checks++; if (busy_out !== 1'b0 || ref_load_done_out !== 1'b0 || len_err_out !== 1'b0) begin errors++; $display("[TB] FAIL midrst_flags: got busy=%b done=%b err=%b want 0/0/0", busy_out, ref_load_done_out, len_err_out); end
    checks++; if (ref_count_out !== '0) begin errors++; $display("[TB] FAIL midrst_count: got %0d want 0", ref_count_out); end
    checks++; if (src_fifo_clear_out !== 1'b1 || src_fifo_rden_out !== 1'b0) begin errors++; $display("[TB] FAIL midrst_fifo: got clear=%b rden=%b want 1/0", src_fifo_clear_out, src_fifo_rden_out); end
    checks++; if ({rd_valid_out, rd_data_out} !== '0) begin errors++; $display("[TB] FAIL midrst_rd: got valid=%h data=%h want 0", rd_valid_out, rd_data_out); end
    rst_in = 1'b0;
    rd_en_in = '0;
    rs_in = 1'b0;
    tick(2);
    checks++; if (busy_out !== 1'b0 || src_fifo_clear_out !== 1'b0) begin errors++; $display("[TB] FAIL midrst_release: got busy=%b clear=%b want 0/0", busy_out, src_fifo_clear_out); end
  endtask

  initial begin
    $display("[TB] starting dtw_ref_mem_multi bench");
    test_reset();
    test_load_read();
    test_fifo_stall();
    test_len_err();
    test_abort_reload();
    test_multi_port();
    test_zero_len();
    test_reset_midload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
